mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that responds on the core's data-memory bus (`wbe`/`addr`/`dataw`/`datar`), alongside `dmem`. Store instructions push bytes into a transmit FIFO; a serializer drains it as 8N1 frames on `serial_out`. The block also exposes a free-running cycle counter. Address decode of the MMIO region is external and arrives as `sel`.

---
 rtl/mmio_uart_tx.sv | 215 +++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a free-running
// cycle counter, sitting on the core's data-memory bus next to dmem.
//
// Build option: define UART_TX_FIFO_EN to buffer transmit bytes in a
// FIFO_DEPTH-entry FIFO. Without it, a single holding register is used.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    TX FIFO entries, power of two 2..128 (FIFO build only)
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   sel         access targets this block (external decode)
//   addr[1:0]   word offset: 0 STATUS, 1 TX_DATA, 2 CYCLE_CNT, 3 CNT_CLR
//   wbe[3:0]    byte write enables; write = sel && wbe != 0
//   dataw[31:0] write data
//   datar[31:0] combinational read data for addr
//   serial_out  UART line, idle high
//   tx_busy     frame on the line or buffer non-empty
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [3:0]  wbe,
  input  logic [31:0] dataw,
  output logic [31:0] datar,
  output logic        serial_out,
  output logic        tx_busy
);

  localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int unsigned       CNT_W     = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_TXDATA = 2'd1;
  localparam logic [1:0] A_CYCCNT = 2'd2;
  localparam logic [1:0] A_CNTCLR = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              serial_q;

  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       cyc_q, cyc_d;

  logic              wr_en, push_req, push_ok, pop, full;
  logic              ovf_clr, cnt_clr;
  logic [7:0]        pop_data;

  // Upper write-data lanes have no destination in this block.
  logic              unused_dataw;
  assign unused_dataw = ^dataw[31:8];

  assign wr_en    = sel && (wbe != '0);
  assign push_req = wr_en && (addr == A_TXDATA) && wbe[0];
  assign ovf_clr  = wr_en && (addr == A_STATUS) && wbe[0] && dataw[2];
  assign cnt_clr  = wr_en && (addr == A_CNTCLR);

  // The serializer takes a byte when idle, or on the last stop-bit cycle
  // so that queued frames go out back-to-back.
  assign pop = (count_q != '0) &&
               ((state_q == S_IDLE) || ((state_q == S_STOP) && (baud_q == BAUD_LAST)));

  // A same-cycle pop frees the slot, so a push into a full buffer still lands.
  assign push_ok = push_req && (!full || pop);

`ifdef UART_TX_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= dataw[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end
`else
  logic [7:0] hold_q;

  // Count shares the FIFO build's width but only ever holds 0 or 1.
  assign full     = (count_q != '0);
  assign pop_data = hold_q;

  always_ff @(posedge clk) begin
    if (push_ok) hold_q <= dataw[7:0];
  end
`endif

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop) count_d = count_q - CNT_W'(1);

    ovf_d = ovf_q;
    if (ovf_clr)              ovf_d = 1'b0;
    if (push_req && !push_ok) ovf_d = 1'b1;

    cyc_d = cnt_clr ? '0 : cyc_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      cyc_q   <= cyc_d;
    end
  end

  // Serializer: the line level is registered alongside each state change,
  // so serial_q always shows the bit of the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          baud_q   <= '0;
          serial_q <= 1'b1;
          if (pop) begin
            shift_q  <= pop_data;
            state_q  <= S_START;
            serial_q <= 1'b0;
          end
        end
        S_START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q   <= '0;
            bit_q    <= '0;
            state_q  <= S_DATA;
            serial_q <= shift_q[0];
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q  <= S_STOP;
              serial_q <= 1'b1;
            end else begin
              bit_q    <= bit_q + 3'd1;
              shift_q  <= shift_q >> 1;
              serial_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (pop) begin
              shift_q  <= pop_data;
              state_q  <= S_START;
              serial_q <= 1'b0;
            end else begin
              state_q  <= S_IDLE;
              serial_q <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q  <= S_IDLE;
          serial_q <= 1'b1;
        end
      endcase
    end
  end

  assign serial_out = serial_q;
  assign tx_busy    = (state_q != S_IDLE) || (count_q != '0);

  always_comb begin
    datar = '0;
    unique case (addr)
      A_STATUS: datar = {16'h0, 8'(count_q), 5'h0, ovf_q, tx_busy, !full};
      A_CYCCNT: datar = cyc_q;
      default:  datar = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Expectations follow the UART_TX_FIFO_EN setting the bench is compiled with.
module tb_mmio_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 10 * CPB;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned M_DEPTH          = DEPTH;
  localparam int unsigned N_ACC            = 5;
  localparam logic [31:0] EXP_BURST_STATUS = 32'h0000_0406;
`else
  localparam int unsigned M_DEPTH          = 1;
  localparam int unsigned N_ACC            = 2;
  localparam logic [31:0] EXP_BURST_STATUS = 32'h0000_0106;
`endif

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_TXDATA = 2'd1;
  localparam logic [1:0] A_CYCCNT = 2'd2;
  localparam logic [1:0] A_CNTCLR = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic [1:0]  addr = '0;
  logic [3:0]  wbe = '0;
  logic [31:0] dataw = '0;
  logic [31:0] datar;
  logic        serial_out;
  logic        tx_busy;

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .addr       (addr),
    .wbe        (wbe),
    .dataw      (dataw),
    .datar      (datar),
    .serial_out (serial_out),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the remaining length of the frame
  // on the line (0 = line idle).
  logic [7:0]  mq[$];
  int unsigned m_tleft;
  logic [7:0]  m_frame;
  logic        m_ovf;
  logic [31:0] m_cnt;

  function automatic void m_reset();
    mq.delete();
    m_tleft = 0;
    m_frame = '0;
    m_ovf   = 1'b0;
    m_cnt   = '0;
  endfunction

  function automatic logic m_busy();
    return (m_tleft != 0) || (mq.size() != 0);
  endfunction

  function automatic logic m_serial();
    int unsigned k;
    if (m_tleft == 0) return 1'b1;
    k = (FRAME - m_tleft) / CPB;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return m_frame[k-1];
  endfunction

  function automatic logic [31:0] m_datar(input logic [1:0] a);
    case (a)
      A_STATUS: return {16'h0, 8'(mq.size()), 5'h0, m_ovf, m_busy(), (mq.size() < M_DEPTH)};
      A_CYCCNT: return m_cnt;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic void m_edge(input logic s, input logic [1:0] a,
                                 input logic [3:0] be, input logic [31:0] d);
    logic wr, push, full, pop;
    wr   = s && (be != 4'h0);
    push = wr && (a == A_TXDATA) && be[0];
    full = (mq.size() == M_DEPTH);
    pop  = (mq.size() != 0) && (m_tleft <= 1);
    if (wr && (a == A_STATUS) && be[0] && d[2]) m_ovf = 1'b0;
    if (push && full && !pop) m_ovf = 1'b1;
    if (pop) begin
      m_frame = mq.pop_front();
      m_tleft = FRAME;
    end else if (m_tleft != 0) begin
      m_tleft--;
    end
    if (push && (!full || pop)) mq.push_back(d[7:0]);
    m_cnt = (wr && (a == A_CNTCLR)) ? 32'h0 : m_cnt + 32'd1;
  endfunction

  // Values sampled in the most recent cycle, and line/busy history.
  logic [31:0] s_datar;
  logic        s_serial, s_busy;
  logic        line_q[$];
  logic        busy_q[$];

  // One clock: drive at the falling edge, sample 1 time unit later,
  // compare with the model, then advance both across the rising edge.
  task automatic cycle(input logic s, input logic [1:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    sel = s; addr = a; wbe = be; dataw = d;
    #1;
    s_datar  = datar;
    s_serial = serial_out;
    s_busy   = tx_busy;
    line_q.push_back(s_serial);
    busy_q.push_back(s_busy);
    check("model_datar", s_datar, m_datar(a));
    check("model_serial", 32'(s_serial), 32'(m_serial()));
    check("model_busy", 32'(s_busy), 32'(m_busy()));
    @(posedge clk);
    m_edge(s, a, be, d);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, A_STATUS, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    sel = 1'b0; addr = '0; wbe = '0; dataw = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_reset();
  endtask

  typedef struct {
    logic [1:0]  a;
    logic [31:0] exp;
  } rd_vec_t;

  typedef struct {
    logic        s;
    logic [1:0]  a;
    logic [3:0]  be;
    logic [31:0] exp_status;
  } wr_vec_t;

  rd_vec_t     rd_tbl[3];
  wr_vec_t     wr_tbl[6];
  logic [9:0]  seq;
  logic [9:0]  got;
  logic [7:0]  b;
  int unsigned busy_n, zeros, base;
  logic        rs;
  int unsigned thr;

  initial begin
    rd_tbl[0] = '{a: A_STATUS, exp: 32'h0000_0001};
    rd_tbl[1] = '{a: A_TXDATA, exp: 32'h0000_0000};
    rd_tbl[2] = '{a: A_CNTCLR, exp: 32'h0000_0000};

    wr_tbl[0] = '{s: 1'b0, a: A_TXDATA, be: 4'b0001, exp_status: 32'h1};
    wr_tbl[1] = '{s: 1'b1, a: A_TXDATA, be: 4'b0000, exp_status: 32'h1};
    wr_tbl[2] = '{s: 1'b1, a: A_TXDATA, be: 4'b1110, exp_status: 32'h1};
    wr_tbl[3] = '{s: 1'b1, a: A_TXDATA, be: 4'b0010, exp_status: 32'h1};
    wr_tbl[4] = '{s: 1'b1, a: A_TXDATA, be: 4'b1000, exp_status: 32'h1};
    wr_tbl[5] = '{s: 1'b1, a: A_CYCCNT, be: 4'b0001, exp_status: 32'h1};

    m_reset();
    do_reset();

    // Reset state and read-only offsets.
    foreach (rd_tbl[i]) begin
      cycle(1'b0, rd_tbl[i].a, 4'h0, 32'h0);
      check("reset_read", s_datar, rd_tbl[i].exp);
      check("reset_serial", 32'(s_serial), 32'h1);
      check("reset_busy", 32'(s_busy), 32'h0);
    end

    // Single 0x55 frame: pop cycle, then 10 bits of CPB cycles each.
    seq = {1'b1, 8'h55, 1'b0};
    cycle(1'b1, A_TXDATA, 4'b0001, 32'h0000_0055);
    busy_n = 0;
    for (int i = 0; i < 45; i++) begin
      idle();
      if (s_busy) busy_n++;
      if (i >= 1 && i <= 40) check("frame55_bit", 32'(s_serial), 32'(seq[(i - 1) / CPB]));
    end
    check("frame55_busy_cycles", busy_n, 32'd41);
    check("frame55_busy_tail", 32'(s_busy), 32'h0);

    // Burst while the first frame is in flight, then one push too many.
    line_q.delete();
    busy_q.delete();
    for (int i = 0; i < 6; i++) cycle(1'b1, A_TXDATA, 4'b0001, 32'hA0 + 32'(i));
    cycle(1'b0, A_STATUS, 4'h0, 32'h0);
    check("burst_status", s_datar, EXP_BURST_STATUS);
    repeat (N_ACC * FRAME + 5) idle();
    for (int f = 0; f < int'(N_ACC); f++) begin
      for (int k = 0; k < 10; k++) got[k] = line_q[3 + f * FRAME + k * CPB];
      b = 8'hA0 + 8'(f);
      check("burst_frame", 32'(got), 32'({1'b1, b, 1'b0}));
    end
    busy_n = 0;
    for (int j = 1; j < busy_q.size(); j++) if (busy_q[j]) busy_n++;
    check("burst_busy_cycles", busy_n, 1 + N_ACC * FRAME);
    check("burst_busy_contig", 32'(busy_q[N_ACC * FRAME]), 32'h1);

    // Overflow is write-1-to-clear through lane 0 only.
    cycle(1'b1, A_STATUS, 4'b0010, 32'h0000_0004);
    cycle(1'b0, A_STATUS, 4'h0, 32'h0);
    check("ovf_kept_wrong_lane", s_datar, 32'h0000_0005);
    cycle(1'b1, A_STATUS, 4'b0001, 32'h0000_0004);
    cycle(1'b0, A_STATUS, 4'h0, 32'h0);
    check("ovf_cleared", s_datar, 32'h0000_0001);

    // Writes that must not enqueue anything.
    foreach (wr_tbl[i]) begin
      cycle(wr_tbl[i].s, wr_tbl[i].a, wr_tbl[i].be, 32'h0000_005A);
      cycle(1'b0, A_STATUS, 4'h0, 32'h0);
      check("ignored_write_status", s_datar, wr_tbl[i].exp_status);
      idle();
      check("ignored_write_line", 32'(s_serial), 32'h1);
    end

    // Cycle counter: 100 edges after reset, then clear.
    do_reset();
    repeat (100) idle();
    cycle(1'b0, A_CYCCNT, 4'h0, 32'h0);
    check("cyc_100", s_datar, 32'd100);
    cycle(1'b1, A_CNTCLR, 4'b1000, 32'h0);
    cycle(1'b0, A_CYCCNT, 4'h0, 32'h0);
    check("cyc_after_clr", s_datar, 32'd0);
    cycle(1'b0, A_CYCCNT, 4'h0, 32'h0);
    check("cyc_after_clr_plus1", s_datar, 32'd1);

    // Reset in the middle of data bit 3 of 0xC3 (bit 3 = 0).
    cycle(1'b1, A_TXDATA, 4'b0001, 32'h0000_00C3);
    repeat (18) idle();
    check("midframe_bit3", 32'(s_serial), 32'h0);
    rst = 1'b0;
    #1;
    check("async_reset_serial", 32'(serial_out), 32'h1);
    check("async_reset_busy", 32'(tx_busy), 32'h0);
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_reset_serial", 32'(serial_out), 32'h1);
    rst = 1'b1;
    cycle(1'b0, A_STATUS, 4'h0, 32'h0);
    check("post_reset_status", s_datar, 32'h0000_0001);
    zeros = 0;
    for (int i = 0; i < 60; i++) begin
      idle();
      if (!s_serial) zeros++;
    end
    check("post_reset_no_frame", zeros, 32'd0);

    // Random bus traffic: a dense phase that keeps the buffer full,
    // then a sparse phase that lets it drain.
    for (int i = 0; i < 3000; i++) begin
      thr = (i < 1500) ? 2 : 16;
      rs  = ($urandom_range(0, thr - 1) == 0);
      cycle(rs, 2'($urandom_range(0, 3)), 4'($urandom), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
